// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI command arbiter.
package spi_arb_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned CMD_W   = 16;

    typedef logic [CMD_W-1:0] cmd_t;

    // Read data returned when a transaction is aborted by the timeout.
    localparam cmd_t TIMEOUT_FILL = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Round-robin pick: on a tie the rr pointer decides, otherwise the lone pending slot wins.
    function automatic logic pick_grant(input logic [NUM_REQ-1:0] pend, input logic rr);
        if (pend[0] && pend[1]) begin
            return rr;
        end
        return pend[1] && !pend[0];
    endfunction

endpackage

// File: rtl/spi_arb_if.sv
// Requester and SPI-monarch signal bundle for spi_arb; slave is the arbiter side.
interface spi_arb_if;
    import spi_arb_pkg::*;

    logic req0;
    logic req1;
    cmd_t cmd0;
    cmd_t cmd1;
    logic busy0;
    logic busy1;
    logic done0;
    logic done1;
    cmd_t rd_data;
    logic spi_wrt;
    cmd_t spi_cmd;
    logic spi_done;
    cmd_t spi_rd_data;
    logic err;

    modport slave (
        input  req0, req1, cmd0, cmd1, spi_done, spi_rd_data,
        output busy0, busy1, done0, done1, rd_data, spi_wrt, spi_cmd, err
    );

    modport master (
        output req0, req1, cmd0, cmd1, spi_done, spi_rd_data,
        input  busy0, busy1, done0, done1, rd_data, spi_wrt, spi_cmd, err
    );

endinterface

// File: rtl/spi_arb_slot.sv
// One-deep request slot: a request loads only into an empty slot, the arbiter clears it on grant.
module spi_arb_slot
    import spi_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  cmd_t cmd,
    input  logic clr,
    output logic pend,
    output cmd_t cmd_q
);

    // Load and clear never coincide: clr only arrives while pend is set, which blocks a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= 1'b0;
            cmd_q <= '0;
        end else if (req && !pend) begin
            pend  <= 1'b1;
            cmd_q <= cmd;
        end else if (clr) begin
            pend  <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI monarch between two requesters.
// Optional BUSY timeout is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic     clk,
    input  logic     rst,
    spi_arb_if.slave bus
);

    state_t               state_q, state_d;
    logic                 gnt_q, gnt_d;
    logic                 rr_q, rr_d;
    logic                 spi_wrt_q, spi_wrt_d;
    cmd_t                 spi_cmd_q, spi_cmd_d;
    cmd_t                 rd_data_q, rd_data_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 err_q, err_d;
    logic [NUM_REQ-1:0]   pend;
    logic [NUM_REQ-1:0]   clr;
    cmd_t                 slot_cmd0, slot_cmd1;
    logic                 grant_c;
    logic                 timeout_c;
    logic                 in_flight_c;

    spi_arb_slot u_slot0 (
        .clk   (clk),
        .rst   (rst),
        .req   (bus.req0),
        .cmd   (bus.cmd0),
        .clr   (clr[0]),
        .pend  (pend[0]),
        .cmd_q (slot_cmd0)
    );

    spi_arb_slot u_slot1 (
        .clk   (clk),
        .rst   (rst),
        .req   (bus.req1),
        .cmd   (bus.cmd1),
        .clr   (clr[1]),
        .pend  (pend[1]),
        .cmd_q (slot_cmd1)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // Counts BUSY cycles; zero whenever BUSY is not active, so it starts clean on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout_c = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign timeout_c      = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign grant_c = pick_grant(pend, rr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            rr_q      <= 1'b0;
            spi_wrt_q <= 1'b0;
            spi_cmd_q <= '0;
            rd_data_q <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            spi_wrt_q <= spi_wrt_d;
            spi_cmd_q <= spi_cmd_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state and registered-output logic; spi_done wins over a same-cycle timeout.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        spi_wrt_d = 1'b0;
        spi_cmd_d = spi_cmd_q;
        rd_data_d = rd_data_q;
        done_d    = '0;
        err_d     = 1'b0;
        clr       = '0;

        unique case (state_q)
            IDLE: begin
                if (|pend) begin
                    gnt_d          = grant_c;
                    rr_d           = !grant_c;
                    spi_wrt_d      = 1'b1;
                    spi_cmd_d      = grant_c ? slot_cmd1 : slot_cmd0;
                    clr[grant_c]   = 1'b1;
                    state_d        = BUSY;
                end
            end
            BUSY: begin
                if (bus.spi_done || timeout_c) begin
                    rd_data_d      = bus.spi_done ? bus.spi_rd_data : TIMEOUT_FILL;
                    err_d          = !bus.spi_done;
                    done_d[gnt_q]  = 1'b1;
                    spi_cmd_d      = '0;
                    state_d        = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_flight_c = (state_q == BUSY);

    assign bus.busy0   = pend[0] | (in_flight_c & ~gnt_q);
    assign bus.busy1   = pend[1] | (in_flight_c & gnt_q);
    assign bus.done0   = done_q[0];
    assign bus.done1   = done_q[1];
    assign bus.rd_data = rd_data_q;
    assign bus.spi_wrt = spi_wrt_q;
    assign bus.spi_cmd = spi_cmd_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_spi_arb.sv
// Directed, table-driven bench for spi_arb with hand sequences for reset and timeout corners.
module tb_spi_arb;
    import spi_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_arb_if bus();

    spi_arb #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        req0;
        logic [15:0] cmd0;
        logic        req1;
        logic [15:0] cmd1;
        logic        sd;
        logic [15:0] srd;
        logic        wrt;
        logic [15:0] scmd;
        logic        b0;
        logic        b1;
        logic        d0;
        logic        d1;
        logic [15:0] rd;
    } vec_t;

    vec_t tbl [24];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t v(input logic r0, input logic [15:0] c0, input logic r1, input logic [15:0] c1,
                               input logic sd, input logic [15:0] srd, input logic wrt, input logic [15:0] scmd,
                               input logic b0, input logic b1, input logic d0, input logic d1,
                               input logic [15:0] rd);
        vec_t t;
        t.req0 = r0;  t.cmd0 = c0;  t.req1 = r1; t.cmd1 = c1;
        t.sd   = sd;  t.srd  = srd; t.wrt  = wrt; t.scmd = scmd;
        t.b0   = b0;  t.b1   = b1;  t.d0   = d0;  t.d1   = d1;
        t.rd   = rd;
        return t;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0 = 1'b0; bus.cmd0 = '0;
        bus.req1 = 1'b0; bus.cmd1 = '0;
        bus.spi_done = 1'b0; bus.spi_rd_data = '0;
    endtask

    // Returns the number of edges until spi_wrt is seen, or -1 if the budget runs out.
    task automatic wait_wrt(input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (bus.spi_wrt === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy0"},   16'(bus.busy0),   16'h0);
        check({tag, " busy1"},   16'(bus.busy1),   16'h0);
        check({tag, " done0"},   16'(bus.done0),   16'h0);
        check({tag, " done1"},   16'(bus.done1),   16'h0);
        check({tag, " spi_wrt"}, 16'(bus.spi_wrt), 16'h0);
        check({tag, " err"},     16'(bus.err),     16'h0);
        check({tag, " spi_cmd"}, bus.spi_cmd,      16'h0000);
        check({tag, " rd_data"}, bus.rd_data,      16'h0000);
    endtask

    initial begin
        int   n;
        logic seen;

        // Each row: inputs applied for one cycle, outputs expected just after that edge.
        tbl[0]  = v(1,16'hA600, 1,16'hA700, 0,16'h0000,  0,16'h0000, 1,1, 0,0, 16'h0000);
        tbl[1]  = v(0,16'h0000, 0,16'h0000, 0,16'h0000,  1,16'hA600, 1,1, 0,0, 16'h0000);
        tbl[2]  = v(0,16'h0000, 0,16'h0000, 1,16'h0012,  0,16'h0000, 0,1, 1,0, 16'h0012);
        tbl[3]  = v(1,16'hA601, 1,16'hA701, 1,16'h2222,  0,16'h0000, 1,1, 0,0, 16'h0012);
        tbl[4]  = v(0,16'h0000, 0,16'h0000, 0,16'h0000,  1,16'hA700, 1,1, 0,0, 16'h0012);
        tbl[5]  = v(0,16'h0000, 0,16'h0000, 1,16'h0034,  0,16'h0000, 1,0, 0,1, 16'h0034);
        tbl[6]  = v(0,16'h0000, 0,16'h0000, 0,16'h0000,  0,16'h0000, 1,0, 0,0, 16'h0034);
        tbl[7]  = v(0,16'h0000, 0,16'h0000, 0,16'h0000,  1,16'hA601, 1,0, 0,0, 16'h0034);
        tbl[8]  = v(0,16'h0000, 0,16'h0000, 1,16'h0056,  0,16'h0000, 0,0, 1,0, 16'h0056);
        tbl[9]  = v(0,16'h0000, 0,16'h0000, 0,16'h0000,  0,16'h0000, 0,0, 0,0, 16'h0056);
        tbl[10] = v(1,16'hB000, 1,16'hB100, 0,16'h0000,  0,16'h0000, 1,1, 0,0, 16'h0056);
        tbl[11] = v(0,16'h0000, 0,16'h0000, 0,16'h0000,  1,16'hB100, 1,1, 0,0, 16'h0056);
        tbl[12] = v(0,16'h0000, 0,16'h0000, 1,16'h0078,  0,16'h0000, 1,0, 0,1, 16'h0078);
        tbl[13] = v(0,16'h0000, 0,16'h0000, 0,16'h0000,  0,16'h0000, 1,0, 0,0, 16'h0078);
        tbl[14] = v(0,16'h0000, 0,16'h0000, 0,16'h0000,  1,16'hB000, 1,0, 0,0, 16'h0078);
        tbl[15] = v(0,16'h0000, 0,16'h0000, 1,16'h009A,  0,16'h0000, 0,0, 1,0, 16'h009A);
        tbl[16] = v(0,16'h0000, 0,16'h0000, 0,16'h0000,  0,16'h0000, 0,0, 0,0, 16'h009A);
        tbl[17] = v(1,16'hC000, 0,16'h0000, 0,16'h0000,  0,16'h0000, 1,0, 0,0, 16'h009A);
        tbl[18] = v(1,16'hC111, 0,16'h0000, 0,16'h0000,  1,16'hC000, 1,0, 0,0, 16'h009A);
        tbl[19] = v(0,16'h0000, 0,16'h0000, 0,16'h0000,  0,16'hC000, 1,0, 0,0, 16'h009A);
        tbl[20] = v(0,16'h0000, 0,16'h0000, 1,16'h00BC,  0,16'h0000, 0,0, 1,0, 16'h00BC);
        tbl[21] = v(0,16'h0000, 0,16'h0000, 0,16'h0000,  0,16'h0000, 0,0, 0,0, 16'h00BC);
        tbl[22] = v(0,16'h0000, 0,16'h0000, 0,16'h0000,  0,16'h0000, 0,0, 0,0, 16'h00BC);
        tbl[23] = v(0,16'h0000, 0,16'h0000, 1,16'h1111,  0,16'h0000, 0,0, 0,0, 16'h00BC);

        rst = 1'b1;
        clear_inputs();
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        for (int i = 0; i < 24; i++) begin
            bus.req0 = tbl[i].req0;  bus.cmd0 = tbl[i].cmd0;
            bus.req1 = tbl[i].req1;  bus.cmd1 = tbl[i].cmd1;
            bus.spi_done = tbl[i].sd; bus.spi_rd_data = tbl[i].srd;
            step();
            check($sformatf("row%0d spi_wrt", i), 16'(bus.spi_wrt), 16'(tbl[i].wrt));
            check($sformatf("row%0d spi_cmd", i), bus.spi_cmd,      tbl[i].scmd);
            check($sformatf("row%0d busy0", i),   16'(bus.busy0),   16'(tbl[i].b0));
            check($sformatf("row%0d busy1", i),   16'(bus.busy1),   16'(tbl[i].b1));
            check($sformatf("row%0d done0", i),   16'(bus.done0),   16'(tbl[i].d0));
            check($sformatf("row%0d done1", i),   16'(bus.done1),   16'(tbl[i].d1));
            check($sformatf("row%0d rd_data", i), bus.rd_data,      tbl[i].rd);
            check($sformatf("row%0d err", i),     16'(bus.err),     16'h0);
        end
        clear_inputs();
        step();

        // Single request while idle: two-clock latency, then completion one cycle after spi_done.
        bus.req0 = 1'b1; bus.cmd0 = 16'hA600;
        wait_wrt(8, n);
        bus.req0 = 1'b0;
        check("idle latency", 16'(n), 16'd2);
        check("idle spi_cmd", bus.spi_cmd, 16'hA600);
        bus.spi_done = 1'b1; bus.spi_rd_data = 16'h0012;
        step();
        clear_inputs();
        check("idle done0",   16'(bus.done0), 16'h1);
        check("idle done1",   16'(bus.done1), 16'h0);
        check("idle rd_data", bus.rd_data,    16'h0012);
        step();
        check("idle done0 one-shot", 16'(bus.done0), 16'h0);

        // Reset during BUSY with a second command queued: everything discarded, stale spi_done ignored.
        bus.req0 = 1'b1; bus.cmd0 = 16'hD000;
        wait_wrt(8, n);
        bus.req0 = 1'b0;
        check("rst-mid reached busy", 16'(n), 16'd2);
        bus.req1 = 1'b1; bus.cmd1 = 16'hD100;
        step();
        bus.req1 = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("rst-mid");
        step();
        rst = 1'b0;
        bus.spi_done = 1'b1; bus.spi_rd_data = 16'h5555;
        step();
        clear_inputs();
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.done0 || bus.done1 || bus.busy0 || bus.busy1 || bus.spi_wrt) seen = 1'b1;
            step();
        end
        check("post-reset quiet", 16'(seen), 16'h0);
        check("post-reset rd_data", bus.rd_data, 16'h0000);

        // After reset the tie goes to requester 0 again.
        bus.req0 = 1'b1; bus.cmd0 = 16'hF000;
        bus.req1 = 1'b1; bus.cmd1 = 16'hF100;
        wait_wrt(8, n);
        clear_inputs();
        check("post-reset latency", 16'(n), 16'd2);
        check("post-reset tie cmd", bus.spi_cmd, 16'hF000);
        bus.spi_done = 1'b1; bus.spi_rd_data = 16'h0F0F;
        step();
        clear_inputs();
        check("post-reset done0", 16'(bus.done0), 16'h1);
        wait_wrt(8, n);
        check("post-reset second cmd", bus.spi_cmd, 16'hF100);
        bus.spi_done = 1'b1; bus.spi_rd_data = 16'h1F1F;
        step();
        clear_inputs();
        check("post-reset done1", 16'(bus.done1), 16'h1);
        step();

`ifdef SPI_ARB_TIMEOUT_EN
        // Withheld spi_done: abort after 16 BUSY cycles with err and fill data.
        bus.req0 = 1'b1; bus.cmd0 = 16'hE000;
        wait_wrt(8, n);
        bus.req0 = 1'b0;
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus.done0 === 1'b1) begin
                n = k;
                break;
            end
        end
        check("timeout cycles",  16'(n),       16'd16);
        check("timeout err",     16'(bus.err), 16'h1);
        check("timeout rd_data", bus.rd_data,  16'hFFFF);
        step();
        check("timeout err one-shot", 16'(bus.err), 16'h0);
        step();

        // spi_done landing on the timeout cycle wins.
        bus.req0 = 1'b1; bus.cmd0 = 16'hE100;
        wait_wrt(8, n);
        bus.req0 = 1'b0;
        repeat (15) step();
        check("race no early done", 16'(bus.done0), 16'h0);
        bus.spi_done = 1'b1; bus.spi_rd_data = 16'h0ABC;
        step();
        clear_inputs();
        check("race done0",   16'(bus.done0), 16'h1);
        check("race err",     16'(bus.err),   16'h0);
        check("race rd_data", bus.rd_data,    16'h0ABC);
`else
        // Without the timeout BUSY waits indefinitely and err never rises.
        bus.req0 = 1'b1; bus.cmd0 = 16'hE000;
        wait_wrt(8, n);
        bus.req0 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (bus.done0 || bus.done1 || bus.err || !bus.busy0) seen = 1'b1;
        end
        check("no-timeout wait", 16'(seen), 16'h0);
        bus.spi_done = 1'b1; bus.spi_rd_data = 16'h0ABC;
        step();
        clear_inputs();
        check("no-timeout done0",   16'(bus.done0), 16'h1);
        check("no-timeout err",     16'(bus.err),   16'h0);
        check("no-timeout rd_data", bus.rd_data,    16'h0ABC);
`endif
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_arb.md
SPI_ARB -- requirements
Module: spi_arb

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 4095, BUSY-state cycle count after which a transaction is aborted (used only when SPI_ARB_TIMEOUT_EN is defined).
REQ-002 clk  input  1  single system clock; all logic rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0 / req1  input  1  one-cycle request strobe from requester 0 / 1.
REQ-005 cmd0 / cmd1  input  16  SPI command word, sampled with the matching req.
REQ-006 busy0 / busy1  output  1  high while the requester has a pending or in-flight transaction.
REQ-007 done0 / done1  output  1  one-cycle completion strobe to requester 0 / 1.
REQ-008 rd_data  output  16  read data from the last completed transaction; valid when any doneN is high.
REQ-009 spi_wrt  output  1  one-cycle start strobe to the SPI monarch.
REQ-010 spi_cmd  output  16  command word to the SPI monarch; held stable from spi_wrt until spi_done.
REQ-011 spi_done  input  1  one-cycle completion strobe from the SPI monarch.
REQ-012 spi_rd_data  input  16  SPI monarch read data; valid when spi_done is high.
REQ-013 err  output  1  one-cycle timeout strobe.

Function
REQ-014 Each requester SHALL have a one-deep slot: reqN with pendN=0 loads cmdN and sets pendN; reqN with pendN=1 is dropped.
REQ-015 busyN SHALL equal pendN OR (transaction in flight AND gnt==N).
REQ-016 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-017 IDLE with a pending slot: at the next edge, grant it, pulse spi_wrt (registered), drive spi_cmd from that slot, clear its pendN, and enter BUSY.
REQ-018 The req-to-spi_wrt latency SHALL be 2 clocks when the arbiter is idle.
REQ-019 With both slots pending, the grant SHALL go to the requester not served last (round-robin); after reset, requester 0 wins the first tie.
REQ-020 In BUSY, spi_done SHALL capture spi_rd_data into rd_data and enter DONE.
REQ-021 In DONE, doneN SHALL be high for exactly one cycle for the granted requester; the next state is IDLE.
REQ-022 Back-to-back transactions SHALL have a minimum spi_done-to-next-spi_wrt gap of 2 clocks.
REQ-023 spi_done in IDLE or DONE SHALL be ignored.
REQ-024 reqN coincident with doneN for the same requester SHALL be accepted, because the slot is free.
REQ-025 Requests SHALL be accepted in any state; slots load independently of the FSM.
REQ-026 spi_cmd SHALL be 16'h0000 while no transaction is in flight.

Reset
REQ-027 While rst is high, all of the following SHALL hold: state=IDLE, pend0=pend1=0, rr pointer favours requester 0, rd_data=0, spi_cmd=0; spi_wrt, done0, done1, err, busy0 and busy1 all 0.
REQ-028 Reset mid-transaction SHALL discard all pending and in-flight work, with no doneN issued; a stale spi_done after reset is ignored per REQ-023.

Configuration
REQ-029 Macro SPI_ARB_TIMEOUT_EN defined: a counter SHALL clear on entering BUSY and increment each BUSY cycle.
REQ-030 On the counter reaching TIMEOUT_CYCLES, the block SHALL pulse err, set rd_data=16'hFFFF, and enter DONE; doneN still pulses.
REQ-031 If spi_done and timeout occur in the same cycle, spi_done SHALL win and err SHALL stay 0.
REQ-032 Macro SPI_ARB_TIMEOUT_EN undefined: there SHALL be no counter, BUSY SHALL wait indefinitely, and err SHALL be tied to 0.

Structure
REQ-033 Package spi_arb_pkg SHALL hold the state enum (IDLE, BUSY, DONE), NUM_REQ=2, and the rd_data timeout fill value 16'hFFFF.
REQ-034 The per-requester slot (pend flag, command register, load/clear) SHALL be sub-module spi_arb_slot, instantiated twice.

Verification
REQ-035 req0 with cmd0=16'hA600 while idle -> spi_wrt 2 clocks later with spi_cmd=A600; spi_done with spi_rd_data=16'h0012 -> done0 next cycle with rd_data=0012.
REQ-036 req0 (A600) and req1 (A700) in the same cycle after reset -> A600 issued first, A700 issued after done0; a following simultaneous pair -> requester 1 served first.
REQ-037 req0 twice while pend0=1 -> second command dropped; exactly one spi_wrt and one done0.
REQ-038 rst asserted in BUSY, then spi_done pulsed after release -> no doneN, busy0=busy1=0, state IDLE.
REQ-039 With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, spi_done withheld -> err and done0 pulse together with rd_data=FFFF; spi_done on the timeout cycle -> err=0 and real data returned.
